// File: rtl/uart_pkg.sv
// Shared encodings for the UART frame transmitter and its future receiver twin.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_e;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/uart_tx_frame_if.sv
// Byte-side ready/valid bundle plus line status for the UART transmitter.
interface uart_tx_frame_if #(
    parameter int DATA_BITS = 8
);

    logic                 i_Tx_DV;
    logic [DATA_BITS-1:0] i_Tx_Byte;
    logic                 o_Tx_Ready;
    logic                 o_Tx_Active;
    logic                 o_Tx_Serial;
    logic                 o_Tx_Done;

    modport master (
        output i_Tx_DV,
        output i_Tx_Byte,
        input  o_Tx_Ready,
        input  o_Tx_Active,
        input  o_Tx_Serial,
        input  o_Tx_Done
    );

    modport slave (
        input  i_Tx_DV,
        input  i_Tx_Byte,
        output o_Tx_Ready,
        output o_Tx_Active,
        output o_Tx_Serial,
        output o_Tx_Done
    );

endinterface

// File: rtl/uart_bit_timer.sv
// Loadable down-counter; tc is high while the count sits at zero.
module uart_bit_timer #(
    parameter int W = 17
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] len,
    output logic         tc
);

    logic [W-1:0] cnt;

    assign tc = (cnt == '0);

    // A zero length behaves as a one-cycle period.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= (len == '0) ? '0 : len - W'(1);
        end else if (cnt != '0) begin
            cnt <= cnt - W'(1);
        end
    end

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmitter: configurable width/parity/stop bits, one-deep holding register.
module uart_tx_frame #(
    parameter int DATA_BITS  = 8,
    parameter int CLK_DIV_W  = 16,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 i_Clock,
    input  logic                 i_Rst_n,
    input  logic [CLK_DIV_W-1:0] i_Clks_Per_Bit,
    uart_tx_frame_if.slave       tx
);

    import uart_pkg::*;

    localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam int TW    = CLK_DIV_W + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);
    localparam logic PAR_MODE = (PARITY_ODD != 0) ? PAR_ODD : PAR_EVEN;

    tx_state_e            state;
    logic [DATA_BITS-1:0] hold;
    logic [DATA_BITS-1:0] shift;
    logic                 hold_valid;
    logic [CLK_DIV_W-1:0] d_q;
    logic [CLK_DIV_W-1:0] d_in;
    logic [IDX_W-1:0]     bit_idx;
    logic                 fin;
    logic                 serial_q;
    logic                 active_q;
    logic                 done_q;
    logic                 tc;
    logic                 t_load;
    logic [TW-1:0]        t_len;
    logic [TW-1:0]        stop_len;
    logic                 line;
    logic                 par_bit;
    logic                 accept;
    logic                 take;

    assign d_in     = (i_Clks_Per_Bit == '0) ? CLK_DIV_W'(1) : i_Clks_Per_Bit;
    assign stop_len = (STOP_BITS == 2) ? {d_q, 1'b0} : {1'b0, d_q};
    assign par_bit  = (^shift) ^ PAR_MODE;
    assign accept   = tx.i_Tx_DV && !hold_valid;
    assign take     = hold_valid &&
                      ((state == IDLE) || ((state == STOP) && tc));

    assign tx.o_Tx_Ready  = !hold_valid;
    assign tx.o_Tx_Active = active_q;
    assign tx.o_Tx_Serial = serial_q;
    assign tx.o_Tx_Done   = done_q;

    always_comb begin
        t_load = 1'b0;
        t_len  = {1'b0, d_q};
        unique case (state)
            IDLE: begin
                t_load = hold_valid;
                t_len  = {1'b0, d_in};
            end
            START:  t_load = tc;
            DATA: begin
                t_load = tc;
                if ((bit_idx == LAST_IDX) && (PARITY_EN == 0))
                    t_len = stop_len;
            end
            PARITY: begin
                t_load = tc;
                t_len  = stop_len;
            end
            STOP: begin
                t_load = tc && hold_valid;
                t_len  = {1'b0, d_in};
            end
            default: t_load = 1'b0;
        endcase
    end

    always_comb begin
        line = 1'b1;
        unique case (state)
            START:   line = 1'b0;
            DATA:    line = shift[bit_idx];
            PARITY:  line = par_bit;
            default: line = 1'b1;
        endcase
    end

    uart_bit_timer #(
        .W(TW)
    ) u_timer (
        .clk   (i_Clock),
        .rst_n (i_Rst_n),
        .load  (t_load),
        .len   (t_len),
        .tc    (tc)
    );

    // Line outputs are a registered view of the state, one cycle behind it.
    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state      <= IDLE;
            hold       <= '0;
            hold_valid <= 1'b0;
            shift      <= '0;
            d_q        <= '0;
            bit_idx    <= '0;
            fin        <= 1'b0;
            serial_q   <= 1'b1;
            active_q   <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            serial_q <= line;
            active_q <= (state != IDLE);
            done_q   <= fin;
            fin      <= 1'b0;
            if (take) begin
                hold_valid <= 1'b0;
            end else if (accept) begin
                hold       <= tx.i_Tx_Byte;
                hold_valid <= 1'b1;
            end
            if (take) begin
                shift   <= hold;
                d_q     <= d_in;
                bit_idx <= '0;
            end
            unique case (state)
                IDLE: begin
                    if (hold_valid)
                        state <= START;
                end
                START: begin
                    if (tc)
                        state <= DATA;
                end
                DATA: begin
                    if (tc) begin
                        if (bit_idx == LAST_IDX) begin
                            bit_idx <= '0;
                            state   <= (PARITY_EN != 0) ? PARITY : STOP;
                        end else begin
                            bit_idx <= bit_idx + IDX_W'(1);
                        end
                    end
                end
                PARITY: begin
                    if (tc)
                        state <= STOP;
                end
                STOP: begin
                    if (tc) begin
                        fin   <= 1'b1;
                        state <= hold_valid ? START : IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Directed bench: four transmitter configurations on a shared clock and reset.
module tb_uart_tx_frame;

    typedef struct {
        int          k;
        logic [15:0] cpb;
        logic [8:0]  data;
        int          nb;
        logic [15:0] bits;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic        dv  [4];
    logic [8:0]  byt [4];
    logic [15:0] cpb [4];
    logic [3:0]  ser, act, dn, rdy;

    int checks = 0;
    int errors = 0;

    uart_tx_frame_if #(.DATA_BITS(8)) if0 ();
    uart_tx_frame_if #(.DATA_BITS(8)) if1 ();
    uart_tx_frame_if #(.DATA_BITS(8)) if2 ();
    uart_tx_frame_if #(.DATA_BITS(7)) if3 ();

    assign if0.i_Tx_DV = dv[0];
    assign if1.i_Tx_DV = dv[1];
    assign if2.i_Tx_DV = dv[2];
    assign if3.i_Tx_DV = dv[3];
    assign if0.i_Tx_Byte = byt[0][7:0];
    assign if1.i_Tx_Byte = byt[1][7:0];
    assign if2.i_Tx_Byte = byt[2][7:0];
    assign if3.i_Tx_Byte = byt[3][6:0];

    assign ser = {if3.o_Tx_Serial, if2.o_Tx_Serial, if1.o_Tx_Serial, if0.o_Tx_Serial};
    assign act = {if3.o_Tx_Active, if2.o_Tx_Active, if1.o_Tx_Active, if0.o_Tx_Active};
    assign dn  = {if3.o_Tx_Done, if2.o_Tx_Done, if1.o_Tx_Done, if0.o_Tx_Done};
    assign rdy = {if3.o_Tx_Ready, if2.o_Tx_Ready, if1.o_Tx_Ready, if0.o_Tx_Ready};

    uart_tx_frame #(.DATA_BITS(8)) dut0 (
        .i_Clock(clk), .i_Rst_n(rst_n), .i_Clks_Per_Bit(cpb[0]), .tx(if0));
    uart_tx_frame #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0)) dut1 (
        .i_Clock(clk), .i_Rst_n(rst_n), .i_Clks_Per_Bit(cpb[1]), .tx(if1));
    uart_tx_frame #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(1)) dut2 (
        .i_Clock(clk), .i_Rst_n(rst_n), .i_Clks_Per_Bit(cpb[2]), .tx(if2));
    uart_tx_frame #(.DATA_BITS(7), .STOP_BITS(2)) dut3 (
        .i_Clock(clk), .i_Rst_n(rst_n), .i_Clks_Per_Bit(cpb[3]), .tx(if3));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [127:0] got,
                       input logic [127:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %0h want %0h", nm, got, want);
        end
    endtask

    // Returns at the falling edge right after the accepting rising edge.
    task automatic send(input int k, input logic [8:0] b);
        bit ok;
        ok = 1'b0;
        @(negedge clk);
        byt[k] = b;
        dv[k]  = 1'b1;
        for (int i = 0; i < 100 && !ok; i++) begin
            if (rdy[k])
                ok = 1'b1;
            @(negedge clk);
        end
        dv[k] = 1'b0;
        chk($sformatf("accept_dut%0d", k), 128'(ok), 128'(1));
    endtask

    task automatic run_vec(input int n, input vec_t v);
        int d;
        int len;
        logic [127:0] gl, ga, gd, gr, el, ea, ed, er;
        d   = (v.cpb == 16'd0) ? 1 : int'(v.cpb);
        len = v.nb * d;
        gl = '0; ga = '0; gd = '0; gr = '0;
        el = '0; ea = '0; ed = '0; er = '0;
        cpb[v.k] = v.cpb;
        send(v.k, v.data);
        chk($sformatf("v%0d_ready_drop", n), 128'(rdy[v.k]), 128'(0));
        for (int c = 1; c <= len + 4; c++) begin
            @(negedge clk);
            gl[c] = ser[v.k];
            ga[c] = act[v.k];
            gd[c] = dn[v.k];
            gr[c] = rdy[v.k];
            if (c == 1)
                cpb[v.k] = 16'd9;
        end
        for (int c = 1; c <= len + 4; c++) begin
            el[c] = (c >= 2 && c < len + 2) ? v.bits[(c - 2) / d] : 1'b1;
            ea[c] = (c >= 2 && c <= len + 1);
            ed[c] = (c == len + 2);
            er[c] = 1'b1;
        end
        chk($sformatf("v%0d_line", n), gl, el);
        chk($sformatf("v%0d_active", n), ga, ea);
        chk($sformatf("v%0d_done", n), gd, ed);
        chk($sformatf("v%0d_ready", n), gr, er);
    endtask

    vec_t vt [9];

    initial begin
        logic [127:0] gl, ga, gd, gr, el, ea, ed, er;
        logic [9:0]   f1, f2;

        vt[0] = '{0, 16'd4, 9'h0A5, 10, 16'({1'b1, 8'hA5, 1'b0})};
        vt[1] = '{1, 16'd4, 9'h0A5, 11, 16'({1'b1, 1'b0, 8'hA5, 1'b0})};
        vt[2] = '{2, 16'd4, 9'h0A5, 11, 16'({1'b1, 1'b1, 8'hA5, 1'b0})};
        vt[3] = '{3, 16'd0, 9'h041, 10, 16'({2'b11, 7'h41, 1'b0})};
        vt[4] = '{0, 16'd3, 9'h000, 10, 16'({1'b1, 8'h00, 1'b0})};
        vt[5] = '{1, 16'd1, 9'h007, 11, 16'({1'b1, 1'b1, 8'h07, 1'b0})};
        vt[6] = '{2, 16'd2, 9'h000, 11, 16'({1'b1, 1'b1, 8'h00, 1'b0})};
        vt[7] = '{3, 16'd2, 9'h07F, 10, 16'({2'b11, 7'h7F, 1'b0})};
        vt[8] = '{0, 16'd1, 9'h0FF, 10, 16'({1'b1, 8'hFF, 1'b0})};

        rst_n = 1'b0;
        for (int k = 0; k < 4; k++) begin
            dv[k]  = 1'b0;
            byt[k] = '0;
            cpb[k] = 16'd4;
        end
        repeat (3) @(negedge clk);
        chk("rst_serial", 128'(ser), 128'(4'hF));
        chk("rst_active", 128'(act), 128'(4'h0));
        chk("rst_done", 128'(dn), 128'(4'h0));
        chk("rst_ready", 128'(rdy), 128'(4'hF));
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int n = 0; n < 9; n++)
            run_vec(n, vt[n]);

        // Back-to-back frames, then a byte offered while the holding register is full.
        gl = '0; ga = '0; gd = '0; gr = '0;
        el = '0; ea = '0; ed = '0; er = '0;
        f1 = {1'b1, 8'h55, 1'b0};
        f2 = {1'b1, 8'h0F, 1'b0};
        cpb[0] = 16'd2;
        send(0, 9'h055);
        for (int c = 0; c <= 70; c++) begin
            if (c > 0)
                @(negedge clk);
            gl[c] = ser[0];
            ga[c] = act[0];
            gd[c] = dn[0];
            gr[c] = rdy[0];
            if (c == 0) begin
                byt[0] = 9'h00F;
                dv[0]  = 1'b1;
            end
            if (c == 2)
                dv[0] = 1'b0;
            if (c == 3) begin
                byt[0] = 9'h0FF;
                dv[0]  = 1'b1;
            end
            if (c == 4)
                dv[0] = 1'b0;
        end
        for (int c = 0; c <= 70; c++) begin
            if (c >= 2 && c <= 21)
                el[c] = f1[(c - 2) / 2];
            else if (c >= 22 && c <= 41)
                el[c] = f2[(c - 22) / 2];
            else
                el[c] = 1'b1;
            ea[c] = (c >= 2 && c <= 41);
            ed[c] = (c == 22 || c == 42);
            er[c] = !(c == 0 || (c >= 2 && c <= 20));
        end
        chk("b2b_line", gl, el);
        chk("b2b_active", ga, ea);
        chk("b2b_done", gd, ed);
        chk("b2b_ready", gr, er);

        // Reset asserted during data bit 3 with a byte pending.
        cpb[0] = 16'd4;
        send(0, 9'h000);
        for (int c = 1; c <= 19; c++) begin
            @(negedge clk);
            if (c == 1) begin
                byt[0] = 9'h0FF;
                dv[0]  = 1'b1;
            end
            if (c == 2)
                dv[0] = 1'b0;
        end
        chk("mid_pre_line", 128'(ser[0]), 128'(0));
        chk("mid_pre_ready", 128'(rdy[0]), 128'(0));
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_line", 128'(ser[0]), 128'(1));
        chk("mid_rst_active", 128'(act[0]), 128'(0));
        chk("mid_rst_ready", 128'(rdy[0]), 128'(1));
        chk("mid_rst_done", 128'(dn[0]), 128'(0));
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        gl = '0; ga = '0; gd = '0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            gl[c] = ser[0];
            ga[c] = act[0];
            gd[c] = dn[0];
        end
        chk("post_rst_line", gl, {68'd0, {60{1'b1}}});
        chk("post_rst_active", ga, 128'd0);
        chk("post_rst_done", gd, 128'd0);
        run_vec(9, vt[0]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_frame.md
Name: uart_tx_frame

Overview:
Parametrised UART transmitter, successor to the fixed 8N1 transmitter. It supports configurable data width, optional even/odd parity, 1 or 2 stop bits, and a runtime baud divisor. A one-entry holding register gives a ready/valid byte interface, so back-to-back frames go out with no idle gap. It sits between the MIPS memory-mapped I/O write path and the board TX pin.

Parameters:
DATA_BITS, 8, data bits per frame; legal range 5..9.
CLK_DIV_W, 16, width of the runtime clocks-per-bit divisor.
PARITY_EN, 0, 1 = append a parity bit after the data bits.
PARITY_ODD, 0, 0 = even parity, 1 = odd parity; ignored when PARITY_EN=0.
STOP_BITS, 1, number of stop bits; legal values 1 or 2.

Ports:
i_Clock  in  1  system clock
i_Rst_n  in  1  reset, asynchronous, active-low
i_Clks_Per_Bit  in  CLK_DIV_W  clock cycles per bit, (Fclk/baud)
i_Tx_DV  in  1  byte valid; accepted on a rising edge where i_Tx_DV & o_Tx_Ready
i_Tx_Byte  in  DATA_BITS  data word, sent LSB first
o_Tx_Ready  out  1  holding register empty
o_Tx_Active  out  1  frame in progress
o_Tx_Serial  out  1  serial line, idles high
o_Tx_Done  out  1  one-cycle pulse at the end of each frame

Behaviour:
- Clocking and reset: one clock. Reset is asynchronous and active-low.
- Reset values: o_Tx_Serial=1, o_Tx_Active=0, o_Tx_Done=0, o_Tx_Ready=1. The holding register is cleared, the FSM is in IDLE, and the counters are 0.
- Reset mid-frame: the line returns high immediately and any pending byte is discarded.
- Ready/valid:
  - o_Tx_Ready = NOT hold_valid, driven from a register only; there is no combinational path from i_Tx_DV.
  - i_Tx_DV while o_Tx_Ready=0 is ignored; the byte is dropped and state is unchanged.
- Divisor:
  - D = i_Clks_Per_Bit, latched when the FSM enters START.
  - D=0 is treated as 1.
  - Changing i_Clks_Per_Bit mid-frame has no effect on the current frame.
- FSM states: IDLE, START, DATA, PARITY, STOP. All outputs are registered.
  - IDLE: serial=1. If hold_valid: move the hold register into the shift register, clear hold_valid, latch D, go to START.
  - START: serial=0 for D cycles, then go to DATA.
  - DATA: serial=shift[bit_idx] for D cycles per bit, bit_idx 0..DATA_BITS-1. After the last bit, go to PARITY if PARITY_EN, else STOP.
  - PARITY: serial = XOR(data) XOR PARITY_ODD, for D cycles, then go to STOP.
  - STOP: serial=1 for STOP_BITS*D cycles. At the end:
    - pulse o_Tx_Done for exactly one cycle;
    - if hold_valid, load the held byte and go straight to START (no idle cycle);
    - otherwise go to IDLE.
- Latency: accept at edge N with the FSM in IDLE -> o_Tx_Serial low after edge N+2.
- Frame length: (1 + DATA_BITS + PARITY_EN + STOP_BITS) * D cycles.
- o_Tx_Active: set on entry to START, cleared on entry to IDLE. It stays high across back-to-back frames.
- o_Tx_Done: asserts in the first cycle after the last stop-bit cycle, coincident with IDLE or the next START.
- Simultaneous events: a byte accepted in the same cycle the FSM leaves STOP or IDLE cannot occur, because Ready=0 whenever hold_valid=1. A new accept can only follow a transfer, one cycle later.
- Counter widths:
  - bit timer is CLK_DIV_W+1 bits wide, to cover 2*D on the stop bits;
  - bit_idx is clog2(DATA_BITS) bits wide.

Decomposition:
- Shared package uart_pkg holds:
  - the state encoding constants (IDLE=3'd0, START=1, DATA=2, PARITY=3, STOP=4);
  - the parity-mode constants.
- One sub-module, uart_bit_timer: a loadable down-counter with terminal-count pulse and 0->1 divisor clamp, reused by a future uart_rx_frame.

Test Plan:
1. D=4, 8N1, send 0xA5 -> line reads 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles. o_Tx_Done pulses once, 40 cycles after the start bit's falling edge. Active is high for exactly 40 cycles.
2. D=4, PARITY_EN=1 -> 0xA5 gives parity bit 0 (even) or 1 (PARITY_ODD=1). Frame length is 44 cycles.
3. D=2, 8N1, offer 0x55 then immediately 0x0F -> Ready drops after the first accept and rises when 0x55 enters START. Second start bit follows the stop bit with no idle cycle. Two Done pulses 20 cycles apart; Active stays high throughout.
4. Third byte offered while Ready=0 -> not transmitted; only two frames appear.
5. i_Clks_Per_Bit=0, DATA_BITS=7, STOP_BITS=2, send 7'h41 -> 1-cycle bits, frame 10 cycles, last two bits high.
6. Assert i_Rst_n=0 during data bit 3 -> o_Tx_Serial=1 and Active=0 without waiting for a clock edge, Ready=1, no Done pulse. After release, the line idles until a new DV.
